// File: rtl/snake_move_controller.sv
// Snake movement controller for a 40x40 board.
// A step tick every TICK_FRAMES vertical-sync falls moves the head one cell.
// The body is stored as a 100-entry ring of 2-bit back-pointers. Before each
// move, a CHECK phase walks the body one segment per cycle to look for a
// self-collision. COMMIT then applies the move in a single cycle.
module snake_move_controller #(
  parameter int TICK_FRAMES = 8,
  parameter int MAX_LEN     = 49,
  parameter int APPLE_POS   = 425
) (
  input  logic         iVGA_CLK,
  input  logic         iRST_n,
  input  logic         iVS,
  input  logic         up,
  input  logic         down,
  input  logic         left,
  input  logic         right,
  input  logic         start,
  output logic [31:0]  stage,
  output logic [31:0]  head_pos,
  output logic [31:0]  head_idx,
  output logic [31:0]  length,
  output logic [199:0] dir_buf,
  output logic [31:0]  score
);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CHECK, S_COMMIT, S_OVER} state_e;

  // Direction codes: 00 up (-40), 01 right (+1), 10 down (+40), 11 left (-1).
  localparam logic [1:0]  DIR_UP    = 2'b00;
  localparam logic [1:0]  DIR_RIGHT = 2'b01;
  localparam logic [1:0]  DIR_DOWN  = 2'b10;
  localparam logic [1:0]  DIR_LEFT  = 2'b11;
  localparam logic [31:0] HEAD_INIT = 32'd820;
  localparam logic [5:0]  ROW_INIT  = 6'd20;
  localparam logic [5:0]  COL_INIT  = 6'd20;
  localparam logic [31:0] LEN_INIT  = 32'd3;

  state_e        state_q, state_d;
  logic [31:0]   stage_q, stage_d;
  logic [31:0]   head_pos_q, head_pos_d;
  logic [5:0]    head_row_q, head_row_d;
  logic [5:0]    head_col_q, head_col_d;
  logic [6:0]    head_idx_q, head_idx_d;
  logic [31:0]   length_q, length_d;
  logic [31:0]   score_q, score_d;
  logic [199:0]  dir_buf_q, dir_buf_d;
  logic [1:0]    heading_q, heading_d;
  logic [1:0]    pending_q, pending_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic          vs_q, vs_d;
  logic [31:0]   next_pos_q, next_pos_d;
  logic [5:0]    next_row_q, next_row_d;
  logic [5:0]    next_col_q, next_col_d;
  logic [31:0]   walk_pos_q, walk_pos_d;
  logic [6:0]    walk_idx_q, walk_idx_d;
  logic [31:0]   walk_cnt_q, walk_cnt_d;

  logic          frame_fall;
  logic          req_valid;
  logic [1:0]    req_dir;
  logic [1:0]    pending_sel;
  logic          wall_hit;
  logic [5:0]    step_row;
  logic [5:0]    step_col;
  logic [1:0]    walk_dir;
  logic [31:0]   seg_pos;
  logic [6:0]    commit_idx;

  // Move a cell index one step in the given direction (no wall handling).
  function automatic logic [31:0] step_pos(input logic [31:0] pos, input logic [1:0] d);
    logic [31:0] r;
    case (d)
      DIR_UP:    r = pos - 32'd40;
      DIR_RIGHT: r = pos + 32'd1;
      DIR_DOWN:  r = pos + 32'd40;
      default:   r = pos - 32'd1;
    endcase
    return r;
  endfunction

  assign frame_fall = vs_q & ~iVS;
  assign walk_dir   = dir_buf_q[{walk_idx_q, 1'b0} +: 2];
  assign seg_pos    = step_pos(walk_pos_q, walk_dir);
  assign commit_idx = (head_idx_q == 7'd0) ? 7'd99 : head_idx_q - 7'd1;

  // Button priority decode, reversal filter, and wall / next-cell lookahead.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    if (up)         req_dir = DIR_UP;
    else if (down)  req_dir = DIR_DOWN;
    else if (left)  req_dir = DIR_LEFT;
    else if (right) req_dir = DIR_RIGHT;
    else            req_valid = 1'b0;

    pending_sel = (req_valid && (req_dir != (heading_q ^ 2'b10))) ? req_dir : pending_q;

    step_row = head_row_q;
    step_col = head_col_q;
    wall_hit = 1'b0;
    case (pending_sel)
      DIR_UP:    begin wall_hit = (head_row_q == 6'd0);  step_row = head_row_q - 6'd1; end
      DIR_RIGHT: begin wall_hit = (head_col_q == 6'd39); step_col = head_col_q + 6'd1; end
      DIR_DOWN:  begin wall_hit = (head_row_q == 6'd39); step_row = head_row_q + 6'd1; end
      default:   begin wall_hit = (head_col_q == 6'd0);  step_col = head_col_q - 6'd1; end
    endcase
  end

  // Next-state logic for the FSM, the body ring, and all registered outputs.
  always_comb begin
    state_d     = state_q;
    head_pos_d  = head_pos_q;
    head_row_d  = head_row_q;
    head_col_d  = head_col_q;
    head_idx_d  = head_idx_q;
    length_d    = length_q;
    score_d     = score_q;
    dir_buf_d   = dir_buf_q;
    heading_d   = heading_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    vs_d        = iVS;
    next_pos_d  = next_pos_q;
    next_row_d  = next_row_q;
    next_col_d  = next_col_q;
    walk_pos_d  = walk_pos_q;
    walk_idx_d  = walk_idx_q;
    walk_cnt_d  = walk_cnt_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          head_pos_d  = HEAD_INIT;
          head_row_d  = ROW_INIT;
          head_col_d  = COL_INIT;
          head_idx_d  = 7'd0;
          length_d    = LEN_INIT;
          score_d     = 32'd0;
          dir_buf_d   = '1;
          heading_d   = DIR_RIGHT;
          pending_d   = DIR_RIGHT;
          frame_cnt_d = 32'd0;
          state_d     = S_PLAY;
        end
      end
      S_PLAY: begin
        pending_d = pending_sel;
        if (frame_fall) begin
          if (frame_cnt_q == 32'(TICK_FRAMES - 1)) begin
            frame_cnt_d = 32'd0;
            if (wall_hit) begin
              state_d = S_OVER;
            end else begin
              next_pos_d = step_pos(head_pos_q, pending_sel);
              next_row_d = step_row;
              next_col_d = step_col;
              walk_pos_d = head_pos_q;
              walk_idx_d = head_idx_q;
              walk_cnt_d = 32'd1;
              state_d    = S_CHECK;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 32'd1;
          end
        end
      end
      S_CHECK: begin
        if (seg_pos == next_pos_q) begin
          state_d = S_OVER;
        end else if (walk_cnt_q >= length_q) begin
          state_d = S_COMMIT;
        end else begin
          walk_pos_d = seg_pos;
          walk_idx_d = (walk_idx_q == 7'd99) ? 7'd0 : walk_idx_q + 7'd1;
          walk_cnt_d = walk_cnt_q + 32'd1;
        end
      end
      S_COMMIT: begin
        head_idx_d = commit_idx;
        dir_buf_d[{commit_idx, 1'b0} +: 2] = pending_q ^ 2'b10;
        head_pos_d = next_pos_q;
        head_row_d = next_row_q;
        head_col_d = next_col_q;
        heading_d  = pending_q;
        if (next_pos_q == 32'(APPLE_POS)) begin
          if (length_q < 32'(MAX_LEN)) length_d = length_q + 32'd1;
          score_d = score_q + 32'd1;
        end
        state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_IDLE:  stage_d = 32'd0;
      S_OVER:  stage_d = 32'd3;
      default: stage_d = 32'd2;
    endcase
  end

  // State registers; reset aborts any in-flight CHECK/COMMIT cleanly.
  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the direction ring is reset as a whole because the initial body is encoded in it.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= S_IDLE;
      stage_q     <= 32'd0;
      head_pos_q  <= HEAD_INIT;
      head_row_q  <= ROW_INIT;
      head_col_q  <= COL_INIT;
      head_idx_q  <= 7'd0;
      length_q    <= LEN_INIT;
      score_q     <= 32'd0;
      dir_buf_q   <= '1;
      heading_q   <= DIR_RIGHT;
      pending_q   <= DIR_RIGHT;
      frame_cnt_q <= 32'd0;
      vs_q        <= 1'b1;
      next_pos_q  <= 32'd0;
      next_row_q  <= 6'd0;
      next_col_q  <= 6'd0;
      walk_pos_q  <= 32'd0;
      walk_idx_q  <= 7'd0;
      walk_cnt_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      head_pos_q  <= head_pos_d;
      head_row_q  <= head_row_d;
      head_col_q  <= head_col_d;
      head_idx_q  <= head_idx_d;
      length_q    <= length_d;
      score_q     <= score_d;
      dir_buf_q   <= dir_buf_d;
      heading_q   <= heading_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      vs_q        <= vs_d;
      next_pos_q  <= next_pos_d;
      next_row_q  <= next_row_d;
      next_col_q  <= next_col_d;
      walk_pos_q  <= walk_pos_d;
      walk_idx_q  <= walk_idx_d;
      walk_cnt_q  <= walk_cnt_d;
    end
  end

  assign stage    = stage_q;
  assign head_pos = head_pos_q;
  assign head_idx = {25'd0, head_idx_q};
  assign length   = length_q;
  assign dir_buf  = dir_buf_q;
  assign score    = score_q;

endmodule

// File: tb/tb_snake_move_controller.sv
// Scoreboard bench for snake_move_controller. The stimulus pushes the expected
// output snapshot for each game event into a queue. A monitor pops a snapshot
// and compares it whenever any output changes. The maximum length is reduced
// so that length saturation can be reached in a short run.
module tb_snake_move_controller;

  localparam int TF = 8;
  localparam int ML = 6;
  localparam int AP = 425;

  localparam logic [3:0] B_NONE = 4'b0000;  // {up, down, left, right}
  localparam logic [3:0] B_UP   = 4'b1000;
  localparam logic [3:0] B_DN   = 4'b0100;
  localparam logic [3:0] B_LT   = 4'b0010;
  localparam logic [3:0] B_RT   = 4'b0001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vs = 1'b1;
  logic         up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  stage, head_pos, head_idx, length, score;
  logic [199:0] dir_buf;

  snake_move_controller #(.TICK_FRAMES(TF), .MAX_LEN(ML), .APPLE_POS(AP)) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs),
    .up(up), .down(down), .left(left), .right(right), .start(start),
    .stage(stage), .head_pos(head_pos), .head_idx(head_idx),
    .length(length), .dir_buf(dir_buf), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  stage;
    logic [31:0]  head_pos;
    logic [31:0]  head_idx;
    logic [31:0]  length;
    logic [31:0]  score;
    logic [199:0] buf_v;
  } snap_t;

  snap_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_buf(input string name, input logic [199:0] got, input logic [199:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural model: the body is kept as an explicit list of cells.
  int          m_body[$];
  int          m_idx, m_len, m_score, m_stage;
  logic [1:0]  m_heading, m_pending;
  logic [199:0] m_buf;

  function automatic snap_t model_snap();
    snap_t s;
    s.stage    = 32'(m_stage);
    s.head_pos = 32'(m_body[0]);
    s.head_idx = 32'(m_idx);
    s.length   = 32'(m_len);
    s.score    = 32'(m_score);
    s.buf_v    = m_buf;
    return s;
  endfunction

  task automatic model_init(input int st);
    m_body    = {820, 819, 818, 817};
    m_idx     = 0;
    m_len     = 3;
    m_score   = 0;
    m_heading = 2'b01;
    m_pending = 2'b01;
    m_buf     = '1;
    m_stage   = st;
  endtask

  task automatic model_tick(input logic [3:0] mask);
    logic [1:0] rq;
    bit has, wall, hit;
    int r, c, nxt;
    has = 1;
    rq  = 2'b00;
    if (mask[3])      rq = 2'b00;
    else if (mask[2]) rq = 2'b10;
    else if (mask[1]) rq = 2'b11;
    else if (mask[0]) rq = 2'b01;
    else              has = 0;
    if (has && rq != (m_heading ^ 2'b10)) m_pending = rq;
    r = m_body[0] / 40;
    c = m_body[0] % 40;
    case (m_pending)
      2'b00:   begin wall = (r == 0);  nxt = m_body[0] - 40; end
      2'b01:   begin wall = (c == 39); nxt = m_body[0] + 1;  end
      2'b10:   begin wall = (r == 39); nxt = m_body[0] + 40; end
      default: begin wall = (c == 0);  nxt = m_body[0] - 1;  end
    endcase
    if (wall) begin
      m_stage = 3;
    end else begin
      hit = 0;
      for (int j = 1; j <= m_len; j++) if (m_body[j] == nxt) hit = 1;
      if (hit) begin
        m_stage = 3;
      end else begin
        m_idx = (m_idx == 0) ? 99 : m_idx - 1;
        m_buf[2*m_idx +: 2] = m_pending ^ 2'b10;
        m_heading = m_pending;
        m_body.push_front(nxt);
        if (nxt == AP) begin
          if (m_len < ML) m_len++;
          m_score++;
        end
        while (m_body.size() > m_len + 1) void'(m_body.pop_back());
      end
    end
    exp_q.push_back(model_snap());
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s.stage    = stage;
    s.head_pos = head_pos;
    s.head_idx = head_idx;
    s.length   = length;
    s.score    = score;
    s.buf_v    = dir_buf;
    return s;
  endfunction

  // Monitor: every output change must match the next queued expectation.
  snap_t mon_prev, mon_cur, mon_exp;
  bit    mon_en = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = dut_snap();
      if (mon_cur !== mon_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_change: stage=%0d head_pos=%0d with nothing expected",
                   mon_cur.stage, mon_cur.head_pos);
        end else begin
          mon_exp = exp_q.pop_front();
          check("mon_stage",    mon_cur.stage,    mon_exp.stage);
          check("mon_head_pos", mon_cur.head_pos, mon_exp.head_pos);
          check("mon_head_idx", mon_cur.head_idx, mon_exp.head_idx);
          check("mon_length",   mon_cur.length,   mon_exp.length);
          check("mon_score",    mon_cur.score,    mon_exp.score);
          check_buf("mon_dir_buf", mon_cur.buf_v, mon_exp.buf_v);
        end
        mon_prev = mon_cur;
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    model_init(2);
    exp_q.push_back(model_snap());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Hold the buttons, issue TF vsync falls, then wait out CHECK and COMMIT.
  task automatic step(input logic [3:0] mask);
    @(negedge clk);
    {up, down, left, right} = mask;
    model_tick(mask);
    for (int i = 0; i < TF; i++) begin
      vs = 1'b0;
      @(negedge clk);
      vs = 1'b1;
      @(negedge clk);
    end
    repeat (ML + 3) @(negedge clk);
    {up, down, left, right} = B_NONE;
  endtask

  task automatic steps(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) step(mask);
  endtask

  // One lap of the 3x4 ring through the apple cell, entered heading up or left.
  task automatic lap();
    steps(B_UP, 2);
    steps(B_RT, 3);
    step(B_DN | B_LT);
    step(B_DN);
    steps(B_LT, 3);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_stage"},    stage,    32'd0);
    check({tag, "_head_pos"}, head_pos, 32'd820);
    check({tag, "_head_idx"}, head_idx, 32'd0);
    check({tag, "_length"},   length,   32'd3);
    check({tag, "_score"},    score,    32'd0);
    check_buf({tag, "_dir_buf"}, dir_buf, {200{1'b1}});
  endtask

  logic [1:0] entry;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    mon_prev = dut_snap();
    mon_en = 1;
    model_init(0);

    // First tick with no buttons moves right.
    do_start();
    step(B_NONE);
    entry = dir_buf[199:198];
    check("t1_head_pos", head_pos, 32'd821);
    check("t1_head_idx", head_idx, 32'd99);
    check("t1_entry99", {30'd0, entry}, 32'd3);
    check("t1_stage", stage, 32'd2);

    // Reversal request is ignored.
    step(B_LT);
    entry = dir_buf[197:196];
    check("rev_head_pos", head_pos, 32'd822);
    check("rev_entry98", {30'd0, entry}, 32'd3);

    // Start while playing is ignored.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_play_stage", stage, 32'd2);
    check("start_in_play_head", head_pos, 32'd822);

    // Reach the apple, grow to 5, then turn back into the body.
    steps(B_RT, 3);
    steps(B_UP, 10);
    check("apple_head_pos", head_pos, 32'd425);
    check("apple_length", length, 32'd4);
    check("apple_score", score, 32'd1);
    lap();
    check("lap_length", length, 32'd5);
    step(B_UP);
    step(B_RT);
    step(B_DN);
    check("self_hit_stage", stage, 32'd3);

    // Restart from game over, then hit the top wall (up beats right).
    do_start();
    repeat (2) @(negedge clk);
    check("restart_head_pos", head_pos, 32'd820);
    check("restart_length", length, 32'd3);
    check("restart_score", score, 32'd0);
    check("restart_stage", stage, 32'd2);
    steps(B_UP | B_RT, 20);
    check("row0_head_pos", head_pos, 32'd20);
    step(B_UP);
    check("wall_stage", stage, 32'd3);
    check("wall_head_pos", head_pos, 32'd20);
    check("wall_head_idx", head_idx, 32'd80);

    // New game: grow to the length limit and eat once more.
    do_start();
    steps(B_RT, 5);
    steps(B_UP, 10);
    lap();
    lap();
    check("full_length", length, 32'(ML));
    lap();
    check("sat_length", length, 32'(ML));
    check("sat_score", score, 32'd4);

    // Asynchronous reset in the middle of CHECK.
    @(negedge clk);
    exp_q.push_back(snap_t'{32'd0, 32'd820, 32'd0, 32'd3, 32'd0, {200{1'b1}}});
    for (int i = 0; i < TF; i++) begin
      vs = 1'b0;
      @(negedge clk);
      if (i < TF - 1) begin
        vs = 1'b1;
        @(negedge clk);
      end
    end
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    @(negedge clk);
    vs = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_init(0);
    do_start();
    step(B_NONE);
    check("post_reset_head_pos", head_pos, 32'd821);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
